// File: rtl/tone_contour_classifier.sv
// Tone contour classifier: captures NUM_FRAMES pitch samples, grades each adjacent
// step against a relative threshold and reports a rise/fall/undulating/neutral class.
module tone_contour_classifier #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_FRAMES = 4,
  parameter int THRESH_PCT = 20
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            external_valid,
  input  logic                            valid_in,
  input  logic                            last_in,
  input  logic signed [DATA_WIDTH-1:0]    data_in,
  input  logic [31:0]                     timeout_cycles,
  output logic                            ready_out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2:0]                      tone_ident,
  output logic [2*(NUM_FRAMES-1)-1:0]     segments_out,
  output logic                            err_timeout
);

  localparam int S  = NUM_FRAMES - 1;
  localparam int FW = $clog2(NUM_FRAMES);
  localparam int PW = DATA_WIDTH + 8;
  localparam logic [DATA_WIDTH:0] DZERO = {(DATA_WIDTH+1){1'b0}};
  localparam logic [FW-1:0]       CZERO = {FW{1'b0}};

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    COMPARE  = 2'd1,
    CLASSIFY = 2'd2,
    REPORT   = 2'd3
  } state_t;

  state_t                 state_r;
  logic [DATA_WIDTH-1:0]  frame_r [NUM_FRAMES];
  logic [FW-1:0]          frame_cnt_r;
  logic [FW-1:0]          seg_idx_r;
  logic [FW-1:0]          seg_nxt_s;
  logic [FW-1:0]          rise_cnt_r;
  logic [FW-1:0]          fall_cnt_r;
  logic [2*S-1:0]         seg_work_r;
  logic [2*S-1:0]         seg_out_r;
  logic [2:0]             tone_r;
  logic [31:0]            idle_r;
  logic [31:0]            idle_inc_s;
  logic                   ready_r;
  logic                   out_valid_r;
  logic                   err_r;
  logic                   capture_s;
  logic [DATA_WIDTH:0]    fa_ext_s;
  logic [DATA_WIDTH:0]    fb_ext_s;
  logic [DATA_WIDTH:0]    d_s;
  logic [DATA_WIDTH:0]    abs_d_s;
  logic [DATA_WIDTH:0]    abs_a_s;
  logic [PW-1:0]          lhs_s;
  logic [PW-1:0]          rhs_s;
  logic                   sig_s;
  logic [1:0]             code_s;
  logic [2:0]             class_s;
  logic [FW:0]            rise_x_s;
  logic [FW:0]            fall_x_s;
  logic [FW:0]            rise2_s;
  logic [FW:0]            fall2_s;

  assign capture_s  = valid_in & last_in & external_valid & (state_r == COLLECT);
  assign idle_inc_s = (idle_r == 32'hFFFF_FFFF) ? idle_r : idle_r + 32'd1;

  // Segment step evaluation: threshold test by cross-multiplication instead of division
  always_comb begin
    seg_nxt_s = seg_idx_r + FW'(1'b1);
    fa_ext_s  = {frame_r[seg_idx_r][DATA_WIDTH-1], frame_r[seg_idx_r]};
    fb_ext_s  = {frame_r[seg_nxt_s][DATA_WIDTH-1], frame_r[seg_nxt_s]};
    d_s       = fb_ext_s - fa_ext_s;
    if (d_s[DATA_WIDTH]) begin
      abs_d_s = ~d_s + (DATA_WIDTH+1)'(1'b1);
    end else begin
      abs_d_s = d_s;
    end
    if (fa_ext_s[DATA_WIDTH]) begin
      abs_a_s = ~fa_ext_s + (DATA_WIDTH+1)'(1'b1);
    end else begin
      abs_a_s = fa_ext_s;
    end
    lhs_s = PW'(abs_d_s) * PW'(7'd100);
    rhs_s = PW'(abs_a_s) * PW'(THRESH_PCT);
    if (fa_ext_s == DZERO) begin
      sig_s = (d_s != DZERO);
    end else begin
      sig_s = (lhs_s >= rhs_s);
    end
    if (sig_s && !d_s[DATA_WIDTH]) begin
      code_s = 2'b01;
    end else if (sig_s && d_s[DATA_WIDTH]) begin
      code_s = 2'b11;
    end else begin
      code_s = 2'b00;
    end
  end

  // Class selection from the rise/fall tallies, first matching rule wins
  always_comb begin
    rise_x_s = {1'b0, rise_cnt_r};
    fall_x_s = {1'b0, fall_cnt_r};
    rise2_s  = {rise_cnt_r, 1'b0};
    fall2_s  = {fall_cnt_r, 1'b0};
    if (rise_cnt_r == CZERO && fall_cnt_r == CZERO) begin
      class_s = 3'b000;
    end else if (fall_cnt_r == CZERO) begin
      class_s = 3'b001;
    end else if (rise_cnt_r == CZERO) begin
      class_s = 3'b100;
    end else if (rise_x_s > fall2_s) begin
      class_s = 3'b001;
    end else if (fall_x_s > rise2_s) begin
      class_s = 3'b100;
    end else begin
      class_s = 3'b010;
    end
  end

  // Control FSM, frame store, idle timer and registered outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r     <= COLLECT;
      for (int i = 0; i < NUM_FRAMES; i++) begin
        frame_r[i] <= {DATA_WIDTH{1'b0}};
      end
      frame_cnt_r <= CZERO;
      seg_idx_r   <= CZERO;
      rise_cnt_r  <= CZERO;
      fall_cnt_r  <= CZERO;
      seg_work_r  <= {(2*S){1'b0}};
      seg_out_r   <= {(2*S){1'b0}};
      tone_r      <= 3'b000;
      idle_r      <= 32'd0;
      ready_r     <= 1'b1;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        COLLECT: begin
          if (capture_s) begin
            frame_r[frame_cnt_r] <= data_in;
            idle_r               <= 32'd0;
            if (frame_cnt_r == FW'(NUM_FRAMES-1)) begin
              frame_cnt_r <= CZERO;
              seg_idx_r   <= CZERO;
              ready_r     <= 1'b0;
              state_r     <= COMPARE;
            end else begin
              frame_cnt_r <= frame_cnt_r + FW'(1'b1);
            end
          end else if (frame_cnt_r != CZERO && timeout_cycles != 32'd0) begin
            // a capture landing on the expiry cycle is handled above and wins
            if (idle_inc_s >= timeout_cycles) begin
              err_r       <= 1'b1;
              frame_cnt_r <= CZERO;
              idle_r      <= 32'd0;
            end else begin
              idle_r <= idle_inc_s;
            end
          end else begin
            idle_r <= 32'd0;
          end
        end
        COMPARE: begin
          seg_work_r[{seg_idx_r, 1'b0} +: 2] <= code_s;
          if (code_s == 2'b01) begin
            rise_cnt_r <= rise_cnt_r + FW'(1'b1);
          end else if (code_s == 2'b11) begin
            fall_cnt_r <= fall_cnt_r + FW'(1'b1);
          end else begin
            rise_cnt_r <= rise_cnt_r;
          end
          if (seg_idx_r == FW'(S-1)) begin
            state_r <= CLASSIFY;
          end else begin
            seg_idx_r <= seg_nxt_s;
          end
        end
        CLASSIFY: begin
          tone_r      <= class_s;
          seg_out_r   <= seg_work_r;
          out_valid_r <= 1'b1;
          state_r     <= REPORT;
        end
        REPORT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            rise_cnt_r  <= CZERO;
            fall_cnt_r  <= CZERO;
            ready_r     <= 1'b1;
            state_r     <= COLLECT;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= COLLECT;
          frame_cnt_r <= CZERO;
          ready_r     <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign ready_out    = ready_r;
  assign out_valid    = out_valid_r;
  assign tone_ident   = tone_r;
  assign segments_out = seg_out_r;
  assign err_timeout  = err_r;

endmodule

// File: doc/tone_contour_classifier.md
TONE_CONTOUR_CLASSIFIER -- requirements
Module: tone_contour_classifier

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, as the signed width of each per-frame pitch/magnitude sample.
REQ-002 The block SHALL take parameter NUM_FRAMES, default 4, range 3..16, as the frames per utterance; segments S = NUM_FRAMES-1.
REQ-003 The block SHALL take parameter THRESH_PCT, default 20, range 1..99, as the minimum relative change, in percent, that counts as a step.
REQ-004 The block SHALL have port clk_in, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port external_valid, input, 1 bit: capture enable from the control path.
REQ-007 The block SHALL have port valid_in, input, 1 bit: the upstream sample is valid.
REQ-008 The block SHALL have port last_in, input, 1 bit: marks the final beat of an FFT frame.
REQ-009 The block SHALL have port data_in, input, DATA_WIDTH bits, signed: the frame sample.
REQ-010 The block SHALL have port timeout_cycles, input, 32 bits: maximum cycles allowed between frame captures; 0 disables the timeout.
REQ-011 The block SHALL have port ready_out, output, 1 bit: the block accepts frames.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the downstream side accepts the result.
REQ-014 The block SHALL have port tone_ident, output, 3 bits: the class code. 000 neutral, 001 rising, 010 undulating, 100 falling.
REQ-015 The block SHALL have port segments_out, output, 2*S bits: per-segment direction codes. 00 none, 01 rise, 11 fall; segment 0 (frame0->frame1) is in bits [1:0].
REQ-016 The block SHALL have port err_timeout, output, 1 bit: a one-cycle pulse on timeout abort.

Function
REQ-017 The FSM SHALL have states COLLECT, COMPARE, CLASSIFY and REPORT; ready_out SHALL be 1 only in COLLECT.
REQ-018 In COLLECT, a capture SHALL occur on a cycle with valid_in && last_in && external_valid. The capture SHALL write data_in into frame slot frame_cnt and increment frame_cnt.
REQ-019 When the capture fills slot NUM_FRAMES-1, the FSM SHALL go to COMPARE and reset frame_cnt to 0.
REQ-020 Capture qualifiers SHALL be ignored in COMPARE, CLASSIFY and REPORT; frames arriving there are dropped.
REQ-021 COMPARE SHALL evaluate one segment per cycle, segment i = frame[i] -> frame[i+1], i = 0..S-1. It SHALL take exactly S cycles, then go to CLASSIFY.
REQ-022 The per-segment calculation SHALL be:
- d = frame[i+1] - frame[i], at DATA_WIDTH+1 bits signed.
- The step is significant iff |d|*100 >= THRESH_PCT*|frame[i]|, with products at DATA_WIDTH+8 bits unsigned.
- No divider SHALL be used.
REQ-023 If frame[i] == 0, the segment SHALL be significant iff d != 0.
REQ-024 A significant segment with d > 0 SHALL be coded 01 and increment rise count R. A significant segment with d < 0 SHALL be coded 11 and increment fall count F. Otherwise the code SHALL be 00.
REQ-025 CLASSIFY SHALL last one cycle and SHALL choose the class in this order:
- R=0 and F=0: neutral.
- F=0: rising.
- R=0: falling.
- R>2F: rising.
- F>2R: falling.
- Otherwise: undulating.
REQ-026 out_valid SHALL rise exactly S+1 cycles after the completing capture edge.
REQ-027 In REPORT, out_valid, tone_ident and segments_out SHALL be held stable until out_valid && out_ready.
REQ-028 On the REPORT handshake cycle, the FSM SHALL go to COLLECT and clear R and F; out_valid SHALL be 0 the next cycle.
REQ-029 Timeout: in COLLECT with frame_cnt > 0 and timeout_cycles != 0, an idle counter SHALL count cycles since the last capture. When it reaches timeout_cycles, the block SHALL pulse err_timeout for 1 cycle, set frame_cnt to 0 and stay in COLLECT.
REQ-030 A capture on the same cycle the idle counter reaches timeout_cycles SHALL win: it SHALL be accepted and SHALL produce no error.
REQ-031 The idle counter SHALL reset on every capture and SHALL saturate rather than wrap.

Reset
REQ-032 While rst_in is high, the block SHALL hold state COLLECT, ready_out=1, out_valid=0, err_timeout=0, tone_ident=000, segments_out=0, frame_cnt=0, R=F=0 and idle counter=0.
REQ-033 Reset asserted in any state, including mid-COMPARE or in REPORT, SHALL immediately abandon the utterance; no out_valid SHALL follow.

Verification (NUM_FRAMES=4, THRESH_PCT=20)
REQ-034 Frames 100,130,170,220 with out_ready=1 -> out_valid 4 cycles after the 4th capture, segments_out=01_01_01, tone_ident=001.
REQ-035 Frames 100,110,115,118 -> segments_out=00_00_00, tone_ident=000. Frames 200,150,100,60 -> segments_out=11_11_11, tone_ident=100.
REQ-036 Frames 100,150,100,150 -> segments_out=01_11_01, tone_ident=010. Frames 0,0,5,5 -> segments_out=00_01_00, tone_ident=001.
REQ-037 A result with out_ready=0 for 5 cycles, plus captures offered during REPORT -> outputs stable and captures ignored; after the handshake, ready_out=1 and frame_cnt=0.
REQ-038 timeout_cycles=10, two captures, then idle -> err_timeout pulses exactly 10 cycles after the 2nd capture. Four new frames then classify normally.
REQ-039 rst_in asserted during the 2nd COMPARE cycle -> all outputs at reset values, no out_valid, and the next 4 frames give a correct result.
